sdspi_arbiter: RTL

Byte-level SPI master that shares the single SD-card SPI path between two requesters: requester 0 is the Z80 I/O-port interface and requester 1 is the boot/image loader. It arbitrates bus ownership round-robin, holds chip-select for the owner across multi-byte commands, and generates mode-0 SCK/MOSI at a programmable rate. It sits upstream of the SD-card power/reset sequencer: `spi_sck`/`spi_mosi` feed its SCK/MOSI inputs, `spi_cs_n` feeds its enable, and `spi_miso` returns from it.

---
 rtl/sdspi_pkg.sv | 17 +
 rtl/sdspi_shifter.sv | 72 +++++++
 rtl/sdspi_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/sdspi_pkg.sv
// Shared types and constants for the SD-card SPI arbiter.
package sdspi_pkg;

    localparam int unsigned NUM_REQ      = 2;
    localparam int unsigned GUARD_CYCLES = 2;
    localparam int unsigned GUARD_W      = 2;
    localparam int unsigned BYTE_W       = 8;
    localparam logic        SPI_IDLE_MOSI = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

endpackage

// File: rtl/sdspi_shifter.sv
// Mode-0 byte shifter: SCK divider, MSB-first TX, RX sampled on rising SCK.
module sdspi_shifter
    import sdspi_pkg::*;
#(
    parameter int unsigned DIV_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [BYTE_W-1:0]   tx,
    input  logic [DIV_BITS-1:0] div,
    input  logic                miso,
    output logic                sck,
    output logic                mosi,
    output logic [BYTE_W-1:0]   rx,
    output logic                busy,
    output logic                done
);

    logic [DIV_BITS-1:0] div_q;
    logic [DIV_BITS-1:0] cnt_q;
    logic [BYTE_W-2:0]   tx_sr;
    logic [BYTE_W-1:0]   rx_sr;
    logic [2:0]          bit_q;

    // Divider, SCK toggling and shift registers; div is latched so later changes have no effect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q <= '0;
            cnt_q <= '0;
            tx_sr <= '0;
            rx_sr <= '0;
            bit_q <= '0;
            sck   <= 1'b0;
            mosi  <= SPI_IDLE_MOSI;
            rx    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load && !busy) begin
                busy  <= 1'b1;
                mosi  <= tx[BYTE_W-1];
                tx_sr <= tx[BYTE_W-2:0];
                div_q <= div;
                cnt_q <= div;
                bit_q <= '0;
                sck   <= 1'b0;
            end else if (busy) begin
                if (cnt_q == '0) begin
                    cnt_q <= div_q;
                    sck   <= ~sck;
                    if (!sck) begin
                        rx_sr <= {rx_sr[BYTE_W-2:0], miso};
                    end else if (bit_q == 3'd7) begin
                        mosi <= SPI_IDLE_MOSI;
                        busy <= 1'b0;
                        done <= 1'b1;
                        rx   <= rx_sr;
                    end else begin
                        mosi  <= tx_sr[BYTE_W-2];
                        tx_sr <= {tx_sr[BYTE_W-3:0], 1'b0};
                        bit_q <= bit_q + 3'd1;
                    end
                end else begin
                    cnt_q <= cnt_q - DIV_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sdspi_arbiter.sv
// Round-robin owner arbitration of the SD-card SPI path with CS hold and guard gap.
module sdspi_arbiter
    import sdspi_pkg::*;
#(
    parameter int unsigned DIV_BITS = 8
) (
    input  logic                clk_peripheral,
    input  logic                reset_n,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  grant,
    input  logic [NUM_REQ-1:0]  start,
    input  logic [BYTE_W-1:0]   tx_data0,
    input  logic [BYTE_W-1:0]   tx_data1,
    input  logic [DIV_BITS-1:0] div,
    output logic                busy,
    output logic                done,
    output logic [BYTE_W-1:0]   rx_data,
    output logic                spi_sck,
    output logic                spi_mosi,
    output logic                spi_cs_n,
    input  logic                spi_miso
);

    state_t             state;
    logic               owner;
    logic               last;
    logic [GUARD_W-1:0] guard_cnt;

    logic               load_c;
    logic               pick_c;
    logic [BYTE_W-1:0]  tx_sel_c;

    // Owner strobe qualification, round-robin pick and TX source select
    always_comb begin
        load_c   = (state == ST_OWNED) && req[owner] && start[owner];
        pick_c   = (req[0] && (last || !req[1])) ? 1'b0 : 1'b1;
        tx_sel_c = owner ? tx_data1 : tx_data0;
    end

    // Ownership FSM: grant, hold CS across bytes, guard gap after release
    always_ff @(posedge clk_peripheral) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            guard_cnt <= '0;
            grant     <= '0;
            spi_cs_n  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != '0) begin
                        owner    <= pick_c;
                        last     <= pick_c;
                        grant    <= NUM_REQ'(1) << pick_c;
                        spi_cs_n <= 1'b0;
                        state    <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (!req[owner]) begin
                        grant     <= '0;
                        spi_cs_n  <= 1'b1;
                        guard_cnt <= GUARD_W'(GUARD_CYCLES - 1);
                        state     <= ST_GUARD;
                    end else if (start[owner]) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (done) begin
                        if (req[owner]) begin
                            state <= ST_OWNED;
                        end else begin
                            grant     <= '0;
                            spi_cs_n  <= 1'b1;
                            guard_cnt <= GUARD_W'(GUARD_CYCLES - 1);
                            state     <= ST_GUARD;
                        end
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt - GUARD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sdspi_shifter #(
        .DIV_BITS(DIV_BITS)
    ) u_shifter (
        .clk     (clk_peripheral),
        .reset_n (reset_n),
        .load    (load_c),
        .tx      (tx_sel_c),
        .div     (div),
        .miso    (spi_miso),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .rx      (rx_data),
        .busy    (busy),
        .done    (done)
    );

endmodule
